// File: rtl/lieat_exu_vpu_wbarb_pkg.sv
// Shared constants for the VPU writeback arbiter slice.
// Lane geometry, default widths and arbitration-mode encodings.
package lieat_exu_vpu_wbarb_pkg;
  localparam int XLEN      = 32;
  localparam int REG_IDX   = 5;
  localparam int MASKW     = XLEN / 8;
  localparam int VLANES    = 8;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/lieat_arb_rr.sv
// N-way one-hot arbiter: fixed priority (highest index wins) or
// round-robin starting at i_ptr and searching upward with wrap.
module lieat_arb_rr
  import lieat_exu_vpu_wbarb_pkg::*;
#(
  parameter int N  = 3,
  parameter int RR = ARB_FIXED,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = |i_req;
    if (RR == ARB_RR) begin
      // Walk from the farthest offset back to ptr so the nearest request wins.
      for (int k = N - 1; k >= 0; k--) begin
        if (i_req[(int'(i_ptr) + k) % N]) o_idx = IW'((int'(i_ptr) + k) % N);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (i_req[k]) o_idx = IW'(k);
      end
    end
    o_grant[o_idx] = o_any;
  end

endmodule

// File: rtl/lieat_exu_vpu_wbarb.sv
// VPU writeback arbiter: merges NSRC execution sources into one
// registered writeback port (1-cycle latency, full throughput).
module lieat_exu_vpu_wbarb #(
  parameter int NSRC    = 3,
  parameter int LANES   = lieat_exu_vpu_wbarb_pkg::VLANES,
  parameter int XLEN    = lieat_exu_vpu_wbarb_pkg::XLEN,
  parameter int REG_IDX = lieat_exu_vpu_wbarb_pkg::REG_IDX,
  parameter int MASKW   = lieat_exu_vpu_wbarb_pkg::MASKW,
  parameter int RR      = lieat_exu_vpu_wbarb_pkg::ARB_FIXED
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NSRC-1:0]               src_valid,
  output logic [NSRC-1:0]               src_ready,
  input  logic [NSRC*XLEN-1:0]          src_pc,
  input  logic [NSRC-1:0]               src_wen,
  input  logic [NSRC-1:0]               src_vwen,
  input  logic [NSRC*REG_IDX-1:0]       src_rd,
  input  logic [NSRC*XLEN-1:0]          src_data,
  input  logic [NSRC*LANES*XLEN-1:0]    src_vdata,
  input  logic [NSRC*LANES*MASKW-1:0]   src_vmask,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic                          out_wen,
  output logic                          out_vwen,
  output logic [REG_IDX-1:0]            out_rd,
  output logic [XLEN-1:0]               out_data,
  output logic [LANES*XLEN-1:0]         out_vdata,
  output logic [LANES*MASKW-1:0]        out_vmask,
  output logic [$clog2(NSRC)-1:0]       out_src
);
  import lieat_exu_vpu_wbarb_pkg::*;

  localparam int SW = $clog2(NSRC);
  localparam int VW = LANES * XLEN;
  localparam int MW = LANES * MASKW;

  logic [NSRC-1:0]    w_grant;
  logic [SW-1:0]      w_idx;
  logic               w_any;
  logic               w_load;
  logic               w_hs;
  logic [XLEN-1:0]    w_pc;
  logic               w_wen;
  logic               w_vwen;
  logic [REG_IDX-1:0] w_rd;
  logic [XLEN-1:0]    w_data;
  logic [VW-1:0]      w_vdata;
  logic [MW-1:0]      w_vmask;

  logic               r_valid;
  logic               r_wen;
  logic               r_vwen;
  logic [XLEN-1:0]    r_pc;
  logic [REG_IDX-1:0] r_rd;
  logic [XLEN-1:0]    r_data;
  logic [VW-1:0]      r_vdata;
  logic [MW-1:0]      r_vmask;
  logic [SW-1:0]      r_src;
  logic [SW-1:0]      r_ptr;

  lieat_arb_rr #(.N(NSRC), .RR(RR), .IW(SW)) u_arb (
    .i_req   (src_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_load    = ~r_valid | out_ready;
  assign w_hs      = w_any & w_load & ~reset;
  assign src_ready = w_grant & {NSRC{w_load & ~reset}};

  assign w_pc    = src_pc[int'(w_idx)*XLEN +: XLEN];
  assign w_wen   = src_wen[w_idx];
  assign w_vwen  = src_vwen[w_idx];
  assign w_rd    = src_rd[int'(w_idx)*REG_IDX +: REG_IDX];
  assign w_data  = src_data[int'(w_idx)*XLEN +: XLEN];
  assign w_vdata = src_vdata[int'(w_idx)*VW +: VW];
  assign w_vmask = src_vmask[int'(w_idx)*MW +: MW];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_wen   <= 1'b0;
      r_vwen  <= 1'b0;
      r_pc    <= '0;
      r_rd    <= '0;
      r_data  <= '0;
      r_vdata <= '0;
      r_vmask <= '0;
      r_src   <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_pc    <= w_pc;
          r_wen   <= w_wen;
          r_vwen  <= w_vwen;
          r_rd    <= (w_wen | w_vwen) ? w_rd : '0;
          r_data  <= w_wen ? w_data : '0;
          r_vdata <= w_vdata;
          r_vmask <= w_vwen ? w_vmask : '0;
          r_src   <= w_idx;
        end else begin
          // Idle beat: payload may linger, but no write may be implied.
          r_wen  <= 1'b0;
          r_vwen <= 1'b0;
        end
      end
      if (RR == ARB_RR && w_hs) r_ptr <= SW'(wrap_inc(int'(w_idx), NSRC));
    end
  end

  assign out_valid = r_valid;
  assign out_wen   = r_wen;
  assign out_vwen  = r_vwen;
  assign out_pc    = r_pc;
  assign out_rd    = r_rd;
  assign out_data  = r_data;
  assign out_vdata = r_vdata;
  assign out_vmask = r_vmask;
  assign out_src   = r_src;

endmodule

// File: tb/tb_lieat_exu_vpu_wbarb.sv
// Directed bench: one fixed-priority and one round-robin instance
// driven by the same sources, checked against hand-computed values.
module tb_lieat_exu_vpu_wbarb;
  localparam int NS = 3;
  localparam int LN = 8;
  localparam int XL = 32;
  localparam int RI = 5;
  localparam int MK = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                reset;
  logic                out_ready;
  logic [NS-1:0]       src_valid;
  logic [NS*XL-1:0]    src_pc;
  logic [NS-1:0]       src_wen;
  logic [NS-1:0]       src_vwen;
  logic [NS*RI-1:0]    src_rd;
  logic [NS*XL-1:0]    src_data;
  logic [NS*LN*XL-1:0] src_vdata;
  logic [NS*LN*MK-1:0] src_vmask;

  logic [NS-1:0]  f_src_ready, q_src_ready;
  logic           f_out_valid, q_out_valid;
  logic [XL-1:0]  f_out_pc, q_out_pc;
  logic           f_out_wen, q_out_wen;
  logic           f_out_vwen, q_out_vwen;
  logic [RI-1:0]  f_out_rd, q_out_rd;
  logic [XL-1:0]  f_out_data, q_out_data;
  logic [LN*XL-1:0] f_out_vdata, q_out_vdata;
  logic [LN*MK-1:0] f_out_vmask, q_out_vmask;
  logic [1:0]     f_out_src, q_out_src;

  lieat_exu_vpu_wbarb #(.NSRC(NS), .LANES(LN), .XLEN(XL), .REG_IDX(RI), .MASKW(MK), .RR(0)) u_fix (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_ready(f_src_ready),
    .src_pc(src_pc), .src_wen(src_wen), .src_vwen(src_vwen), .src_rd(src_rd),
    .src_data(src_data), .src_vdata(src_vdata), .src_vmask(src_vmask),
    .out_valid(f_out_valid), .out_ready(out_ready), .out_pc(f_out_pc), .out_wen(f_out_wen),
    .out_vwen(f_out_vwen), .out_rd(f_out_rd), .out_data(f_out_data), .out_vdata(f_out_vdata),
    .out_vmask(f_out_vmask), .out_src(f_out_src)
  );

  lieat_exu_vpu_wbarb #(.NSRC(NS), .LANES(LN), .XLEN(XL), .REG_IDX(RI), .MASKW(MK), .RR(1)) u_rr (
    .clock(clock), .reset(reset), .src_valid(src_valid), .src_ready(q_src_ready),
    .src_pc(src_pc), .src_wen(src_wen), .src_vwen(src_vwen), .src_rd(src_rd),
    .src_data(src_data), .src_vdata(src_vdata), .src_vmask(src_vmask),
    .out_valid(q_out_valid), .out_ready(out_ready), .out_pc(q_out_pc), .out_wen(q_out_wen),
    .out_vwen(q_out_vwen), .out_rd(q_out_rd), .out_data(q_out_data), .out_vdata(q_out_vdata),
    .out_vmask(q_out_vmask), .out_src(q_out_src)
  );

  int ncmp;
  int nfail;
  logic [LN*XL-1:0] exp_v;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [31:0] pc, input logic wen, input logic vwen,
                         input logic [4:0] rd, input logic [31:0] data, input logic [31:0] base,
                         input logic [3:0] mask);
    src_pc[i*XL +: XL]   = pc;
    src_wen[i]           = wen;
    src_vwen[i]          = vwen;
    src_rd[i*RI +: RI]   = rd;
    src_data[i*XL +: XL] = data;
    for (int j = 0; j < LN; j++) begin
      src_vdata[(i*LN+j)*XL +: XL] = base + 32'(j);
      src_vmask[(i*LN+j)*MK +: MK] = mask;
    end
  endtask

  initial begin
    ncmp = 0;
    nfail = 0;
    reset = 1'b1;
    out_ready = 1'b1;
    src_valid = '0;
    src_pc = '0; src_wen = '0; src_vwen = '0; src_rd = '0;
    src_data = '0; src_vdata = '0; src_vmask = '0;
    for (int i = 0; i < NS; i++)
      set_src(i, 32'h1000 + 32'(i), 1'b1, 1'b0, 5'(i + 1), 32'hA0 + 32'(i), 32'h1000_0000 * 32'(i), 4'hF);
    src_valid = 3'b111;

    // Reset state, with sources already requesting
    tick(); tick();
    chk("rst_valid_fix", f_out_valid, 0);
    chk("rst_valid_rr", q_out_valid, 0);
    chk("rst_ready_fix", f_src_ready, 0);
    chk("rst_ready_rr", q_src_ready, 0);
    chk("rst_src_rr", q_out_src, 0);
    chk("rst_pc_fix", f_out_pc, 0);
    chk("rst_vdata_fix", f_out_vdata, 0);

    reset = 1'b0;
    #1;
    chk("fix_ready_first", f_src_ready, 3'b100);
    chk("rr_ready_first", q_src_ready, 3'b001);

    // Streaming: fixed always picks 2, RR rotates 0,1,2,...
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("fix_valid_stream", f_out_valid, 1);
      chk("fix_src_stream", f_out_src, 2);
      chk("rr_valid_stream", q_out_valid, 1);
      chk("rr_src_stream", q_out_src, k % 3);
    end
    chk("fix_pc", f_out_pc, 32'h1002);
    chk("fix_data", f_out_data, 32'hA2);
    chk("fix_rd", f_out_rd, 3);
    chk("fix_wen", f_out_wen, 1);
    chk("rr_pc_last", q_out_pc, 32'h1002);

    // Backpressure for 3 cycles
    out_ready = 1'b0;
    #1;
    chk("bp_ready_fix", f_src_ready, 0);
    chk("bp_ready_rr", q_src_ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_hold_valid", q_out_valid, 1);
      chk("bp_hold_src", q_out_src, 2);
      chk("bp_hold_pc", q_out_pc, 32'h1002);
      chk("bp_hold_ready_rr", q_src_ready, 0);
      chk("bp_hold_ready_fix", f_src_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready_rr", q_src_ready, 3'b001);
    chk("bp_release_ready_fix", f_src_ready, 3'b100);
    tick();
    chk("bp_after_src_rr", q_out_src, 0);
    chk("bp_after_pc_rr", q_out_pc, 32'h1000);
    chk("bp_after_src_fix", f_out_src, 2);

    // Field gating: vector-only write from source 2
    set_src(2, 32'h2002, 1'b0, 1'b1, 5'd7, 32'hDEAD, 32'h2000_0000, 4'h3);
    src_vmask[(2*LN)*MK +: MK] = 4'hF;
    src_valid = 3'b100;
    for (int j = 0; j < LN; j++) exp_v[j*XL +: XL] = 32'h2000_0000 + 32'(j);
    tick();
    chk("gate_src_rr", q_out_src, 2);
    chk("gate_data", q_out_data, 0);
    chk("gate_rd", q_out_rd, 7);
    chk("gate_vmask", q_out_vmask, 32'h3333_333F);
    chk("gate_vwen", q_out_vwen, 1);
    chk("gate_wen", q_out_wen, 0);
    chk("gate_vdata_fix", f_out_vdata, exp_v);

    set_src(2, 32'h2002, 1'b0, 1'b0, 5'd7, 32'hDEAD, 32'h2000_0000, 4'h3);
    tick();
    chk("nowr_rd", q_out_rd, 0);
    chk("nowr_vmask", q_out_vmask, 0);
    chk("nowr_wen", q_out_wen, 0);
    chk("nowr_vwen", q_out_vwen, 0);
    chk("nowr_valid", q_out_valid, 1);
    chk("nowr_vdata", q_out_vdata, exp_v);

    // Lane packing from source 1
    src_valid = 3'b010;
    for (int j = 0; j < LN; j++) exp_v[j*XL +: XL] = 32'h1000_0000 + 32'(j);
    tick();
    chk("lane_src_rr", q_out_src, 1);
    chk("lane_src_fix", f_out_src, 1);
    chk("lane_vdata", q_out_vdata, exp_v);
    chk("lane_vmask", q_out_vmask, 0);
    chk("lane_data", q_out_data, 32'hA1);

    // Idle beat clears valid and write enables
    src_valid = 3'b000;
    tick();
    chk("idle_valid_rr", q_out_valid, 0);
    chk("idle_wen_rr", q_out_wen, 0);
    chk("idle_valid_fix", f_out_valid, 0);
    chk("idle_wen_fix", f_out_wen, 0);

    // RR wrap: ptr is 2, only 0 and 1 request
    src_valid = 3'b011;
    #1;
    chk("wrap_ready_rr", q_src_ready, 3'b001);
    chk("wrap_ready_fix", f_src_ready, 3'b010);
    tick();
    chk("wrap_src_rr", q_out_src, 0);
    chk("wrap_src_fix", f_out_src, 1);
    chk("wrap_next_ready_rr", q_src_ready, 3'b010);

    // Reset in the middle of a stream
    src_valid = 3'b111;
    reset = 1'b1;
    #1;
    chk("mrst_ready_rr", q_src_ready, 0);
    chk("mrst_ready_fix", f_src_ready, 0);
    tick();
    chk("mrst_valid_rr", q_out_valid, 0);
    chk("mrst_valid_fix", f_out_valid, 0);
    chk("mrst_src_rr", q_out_src, 0);
    chk("mrst_pc_rr", q_out_pc, 0);
    chk("mrst_data_rr", q_out_data, 0);
    chk("mrst_rd_rr", q_out_rd, 0);
    chk("mrst_wen_rr", q_out_wen, 0);
    chk("mrst_vdata_rr", q_out_vdata, 0);
    chk("mrst_vmask_rr", q_out_vmask, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready_rr", q_src_ready, 3'b001);
    chk("post_rst_ready_fix", f_src_ready, 3'b100);
    tick();
    chk("post_rst_src_rr", q_out_src, 0);
    chk("post_rst_src_fix", f_out_src, 2);
    chk("post_rst_valid_rr", q_out_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/lieat_exu_vpu_wbarb.md
Name: lieat_exu_vpu_wbarb

Overview:
- Parametrised VPU writeback arbiter; successor of the fixed 3-source combinational writeback mux.
- Merges NSRC VPU execution sources (e.g. vset, vint, vlsu, future vfpu) into one writeback port toward the commit/regfile stage.
- Selectable fixed-priority or round-robin arbitration.
- Registered output stage: one-cycle latency, full throughput.

Parameters:
- NSRC, 3, number of source channels (2..8); index NSRC-1 is highest priority in fixed mode.
- LANES, 8, vector lanes per writeback beat.
- XLEN, 32, scalar/lane data width.
- REG_IDX, 5, register index width.
- MASKW, 4, byte-mask bits per lane (XLEN/8).
- RR, 0, arbitration mode: 0 = fixed priority, 1 = round-robin.

Ports:
- clock  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- src_valid  in  NSRC  per-source result valid.
- src_ready  out  NSRC  per-source accept.
- src_pc  in  NSRC*XLEN  per-source PC; source i occupies bits [i*XLEN +: XLEN].
- src_wen  in  NSRC  scalar (x-reg) write enable.
- src_vwen  in  NSRC  vector-register write enable.
- src_rd  in  NSRC*REG_IDX  destination index.
- src_data  in  NSRC*XLEN  scalar write data.
- src_vdata  in  NSRC*LANES*XLEN  lane data; source i, lane j at [(i*LANES+j)*XLEN +: XLEN].
- src_vmask  in  NSRC*LANES*MASKW  lane byte masks, same packing as src_vdata.
- out_valid  out  1  writeback beat valid.
- out_ready  in  1  downstream accept.
- out_pc  out  XLEN  PC of the winning source.
- out_wen  out  1  scalar write enable.
- out_vwen  out  1  vector write enable.
- out_rd  out  REG_IDX  destination index.
- out_data  out  XLEN  scalar data.
- out_vdata  out  LANES*XLEN  lane data.
- out_vmask  out  LANES*MASKW  lane masks.
- out_src  out  clog2(NSRC)  index of the winning source.

Behaviour:
- Reset: out_valid=0, out_wen=0, out_vwen=0; out_pc, out_rd, out_data, out_vdata, out_vmask, out_src all 0; RR pointer=0.
- Stage enable: load = ~out_valid | out_ready.
- Grant: one-hot over src_valid, computed combinationally each cycle.
  - Fixed mode: highest valid index wins.
  - RR mode: first valid index searching upward from ptr, with wrap (ptr, ptr+1, ..., NSRC-1, 0, ...).
- src_ready[i] = grant[i] & load. Non-granted sources see ready=0. A source's ready must not depend on its own valid beyond the grant.
- Handshake: when any src_valid and load, the output register captures the winner's fields and out_valid becomes 1 on the next cycle. Latency is exactly 1 cycle.
- If load and no source is valid: out_valid clears to 0. Data registers may hold their values, but out_wen and out_vwen are cleared.
- If out_valid and ~out_ready: all registers hold, all src_ready=0 (backpressure).
- Back-to-back handshakes sustain one beat per cycle while out_ready=1.
- Field gating on capture:
  - out_wen = winner wen.
  - out_data = winner wen ? data : 0.
  - out_vwen = winner vwen.
  - out_vmask = winner vwen ? vmask : 0.
  - out_vdata = winner vdata, passed ungated.
  - out_rd = (wen | vwen) ? rd : 0.
- If a source asserts wen and vwen together, both are propagated unchanged; the downstream stage handles it.
- RR pointer updates only on a source handshake: ptr <= (granted index + 1) mod NSRC, with wrap at NSRC-1 → 0. It holds otherwise, including while stalled.
- Fixed mode: the pointer is unused; lower-priority starvation is permitted by design.
- Reset asserted mid-transfer: in-flight output beat dropped, out_valid=0 next cycle, no src_ready asserted during the reset cycle.

Decomposition:
- Shared package/defines: XLEN, REG_IDX, MASKW, VLANES constants, and an arbitration-mode constant (ARB_FIXED=0, ARB_RR=1).
- One sub-module is natural: lieat_arb_rr (parametrised N-way one-hot arbiter, with ptr input, fixed/RR select, grant and index outputs).
- Output register and field gating stay in the top module.

Test Plan:
- Fixed, NSRC=3: all three valid, out_ready=1 → grants 2, 2, ...; out_src=2, out_valid one cycle after the handshake; src_ready=3'b100.
- RR: all three valid continuously, out_ready=1 → out_src sequence 0, 1, 2, 0, 1, 2 on consecutive cycles; one beat per cycle.
- Backpressure: out_ready held 0 for 3 cycles with out_valid=1 → outputs stable, src_ready=0, ptr unchanged; on release, the next beat is accepted in the same cycle.
- Gating: winner wen=0, vwen=1, rd=5'd7, vmask lane0=4'hF, data=32'hDEAD → out_data=0, out_rd=7, out_vmask lane0=4'hF.
  - Same with vwen=0, wen=0 → out_rd=0 and out_vmask=0.
- Lane packing: source 1 drives lane j data = 32'h1000_0000+j, LANES=8 → out_vdata lane j equals 32'h1000_0000+j for every j.
- Reset mid-stream: reset asserted while out_valid=1 and sources valid → next cycle out_valid=0, ptr=0, all outputs 0; first grant after reset follows the mode's priority from index 0.
